dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-cycle MIPS system's one data memory between the core's load/store port (requester 0) and a loader/debug port (requester 1). It grants one access at a time with round-robin fairness and converts the 2-bit `memwrite` size code into byte enables with lane-replicated write data. It returns read data to the owning requester one cycle after grant. It sits between `top`'s datapath or loader and the synchronous data RAM.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width. Fixed at 32 for lane logic.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rN_req`  in  1  request from requester N (N=0,1). Held until `rN_gnt`.
- `rN_adr`  in  AW  byte address. Stable while `rN_req` is high.
- `rN_wdata`  in  DW  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rN_memwrite`  in  2  size code: 00 read, 01 byte store, 10 half store, 11 word store.
- `rN_gnt`  out  1  access accepted this cycle. Combinational.
- `rN_rvalid`  out  1  read data valid, one-cycle pulse.
- `rN_rdata`  out  DW  read data. Equals `m_rdata` when `rN_rvalid` is high, else 0.
- `rN_err`  out  1  misaligned store rejected. Pulses with `rN_gnt`.
- `m_adr`  out  AW  memory address, word-aligned (`[1:0]` forced to 00).
- `m_we`  out  1  memory write strobe.
- `m_be`  out  4  byte enables.
- `m_wdata`  out  DW  lane-replicated store data.
- `m_re`  out  1  memory read strobe.
- `m_rdata`  in  DW  memory read data, valid the cycle after `m_re`.

## Operation
- FSM states: IDLE and RDATA. A `owner` flop (0/1) and a `last` flop (0/1) hold arbitration state.
- **IDLE, no request:** all `m_*` strobes are 0.
- **IDLE, one request:** that requester gets `gnt`.
- **IDLE, both requesting:** grant goes to the requester ≠ `last`. `last` updates to the granted index on every grant.
- **Granted read** (memwrite 00): `m_re`=1 and `m_be`=1111. `owner` ← index. Next state is RDATA.
- **Granted store:** `m_we`=1 and the state stays in IDLE, so back-to-back stores are possible. Byte enables and data by size:
  - Byte: `m_be` = 0001 << adr[1:0], `m_wdata` = {4{wdata[7:0]}}.
  - Half: `m_be` = adr[1] ? 1100 : 0011, `m_wdata` = {2{wdata[15:0]}}.
  - Word: `m_be` = 1111, `m_wdata` = wdata.
- **Misaligned store** (half with adr[0]=1, or word with adr[1:0]≠0): `gnt` and `err` both pulse, and `m_we`=0 (nothing is written). `last` still updates.
- **RDATA:** `r[owner]_rvalid`=1 and `r[owner]_rdata`=`m_rdata`. No grant is issued. Returns to IDLE unconditionally.
- A request that arrives while in RDATA is held by the requester and arbitrated in the next IDLE cycle.

## Timing
- **Reset values:** state=IDLE, `owner`=0, `last`=1 (requester 0 wins the first tie). All outputs are 0, including `rvalid`, `gnt`, `err`, and all `m_*`.
- **Grant latency:** 0 cycles. `gnt` is asserted in the same cycle as `req` when in IDLE. The memory samples `m_*` at the following rising edge.
- **Read latency:** `rvalid` is asserted exactly 1 cycle after `gnt`.
- **Throughput:** reads, 1 per 2 cycles; stores, 1 per cycle.
- **Reset asserted mid-read:** state goes to IDLE immediately, `rvalid` drops asynchronously, and the pending read is discarded. The requester must re-request.
- **Simultaneous events:** requester 1 asserting `req` in the same cycle as requester 0's `rvalid` is served in the cycle after.
- **Starvation bound:** a continuously requesting port is granted within 2 arbitration rounds.

## Structure
- Package `mips_mem_pkg` holds:
  - the `memwrite_t` enum (MW_READ, MW_BYTE, MW_HALF, MW_WORD);
  - the `arb_state_t` enum (ARB_IDLE, ARB_RDATA);
  - the constant `BE_ALL = 4'b1111`.
- Sub-module `dmem_lane_decode` (combinational): takes size, adr[1:0], and wdata; produces `m_be`, `m_wdata`, and `misaligned`. It is instantiated once, on the granted requester's muxed inputs.

## Test plan
- **Core word store:** r0 stores word 32'hFFFF7F02 at adr 84. Required response: `r0_gnt` in the same cycle, `m_we`=1, `m_adr`=84, `m_be`=1111, `m_wdata`=FFFF7F02.
- **Byte store:** r1 stores byte 8'h5A at adr 0x47. Required response: `m_be`=1000, `m_wdata`=5A5A5A5A, `m_adr`=0x44.
- **Read:** r0 reads adr 0x10 while the memory returns 0xDEADBEEF. Required response: `r0_rvalid`=1 one cycle after `gnt`, `r0_rdata`=DEADBEEF, `r1_rdata`=0.
- **Contention:** r0 and r1 both request continuously from reset (word reads). Required grant order: r0, r1, r0, r1, with each grant 2 cycles apart.
- **Misaligned store:** r0 issues a half store at adr 0x21. Required response: `r0_gnt`=1, `r0_err`=1, `m_we`=0, memory unchanged.
- **Reset mid-read:** drop `reset` low in the RDATA cycle. Required response: `rvalid`=0 within the same cycle, and state IDLE after reset is released.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory arbiter and its lane decoder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MW_READ = 2'b00,
        MW_BYTE = 2'b01,
        MW_HALF = 2'b10,
        MW_WORD = 2'b11
    } memwrite_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_RDATA = 1'b1
    } arb_state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/dmem_lane_decode.sv
// Converts a size code and the low address bits into byte enables, lane-replicated
// store data and a misalignment flag. Reads report all lanes enabled.
module dmem_lane_decode
    import mips_mem_pkg::*;
(
    input  memwrite_t   size,
    input  logic [1:0]  adr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misaligned
);

    // Lane selection and data replication by access size.
    always_comb begin
        be         = BE_ALL;
        lane_wdata = wdata;
        misaligned = 1'b0;
        case (size)
            MW_BYTE: begin
                be         = 4'b0001 << adr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            MW_HALF: begin
                be         = adr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                misaligned = adr_lo[0];
            end
            MW_WORD: begin
                misaligned = (adr_lo != 2'b00);
            end
            default: begin
                be         = BE_ALL;
                lane_wdata = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between the core's
// load/store port (r0) and the loader/debug port (r1).
//
// state     | meaning
// ARB_IDLE  | arbitrate; grant a read or store combinationally
// ARB_RDATA | memory returns read data to the owner; no grant
module dmem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_adr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [1:0]    r0_memwrite,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_err,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_adr,
    input  logic [DW-1:0] r1_wdata,
    input  logic [1:0]    r1_memwrite,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_err,
    output logic [AW-1:0] m_adr,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [DW-1:0] m_wdata,
    output logic          m_re,
    input  logic [DW-1:0] m_rdata
);

    arb_state_t    state;
    logic          owner;
    logic          last;

    logic          sel;
    logic          grant;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_wdata;
    memwrite_t     sel_size;
    logic          sel_read;
    logic [3:0]    dec_be;
    logic [DW-1:0] dec_wdata;
    logic          misaligned;
    logic          store_ok;

    // Pick the winner: on a tie the requester that did not win last time.
    always_comb begin
        if (r0_req && r1_req) sel = ~last;
        else                  sel = r1_req;
        grant     = reset && (state == ARB_IDLE) && (r0_req || r1_req);
        sel_adr   = sel ? r1_adr : r0_adr;
        sel_wdata = sel ? r1_wdata : r0_wdata;
        sel_size  = memwrite_t'(sel ? r1_memwrite : r0_memwrite);
        sel_read  = (sel_size == MW_READ);
    end

    dmem_lane_decode u_lane (
        .size       (sel_size),
        .adr_lo     (sel_adr[1:0]),
        .wdata      (sel_wdata),
        .be         (dec_be),
        .lane_wdata (dec_wdata),
        .misaligned (misaligned)
    );

    // Memory strobes and requester handshakes; a misaligned store is granted but writes nothing.
    always_comb begin
        store_ok  = grant && !sel_read && !misaligned;
        r0_gnt    = grant && !sel;
        r1_gnt    = grant && sel;
        r0_err    = grant && !sel && !sel_read && misaligned;
        r1_err    = grant && sel && !sel_read && misaligned;
        m_re      = grant && sel_read;
        m_we      = store_ok;
        m_adr     = grant ? {sel_adr[AW-1:2], 2'b00} : '0;
        m_be      = (m_re || store_ok) ? dec_be : 4'b0000;
        m_wdata   = store_ok ? dec_wdata : '0;
        r0_rvalid = (state == ARB_RDATA) && !owner;
        r1_rvalid = (state == ARB_RDATA) && owner;
        r0_rdata  = r0_rvalid ? m_rdata : '0;
        r1_rdata  = r1_rvalid ? m_rdata : '0;
    end

    // Arbitration state: reads take a data-return cycle, stores stay in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        last <= sel;
                        if (sel_read) begin
                            owner <= sel;
                            state <= ARB_RDATA;
                        end
                    end
                end
                ARB_RDATA: state <= ARB_IDLE;
                default:   state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stores, reads, arbitration order, misalignment and reset.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r1_req;
    logic [31:0] r0_adr, r1_adr, r0_wdata, r1_wdata;
    logic [1:0]  r0_memwrite, r1_memwrite;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] m_adr, m_wdata, m_rdata;
    logic        m_we, m_re;
    logic [3:0]  m_be;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_adr(r0_adr), .r0_wdata(r0_wdata), .r0_memwrite(r0_memwrite),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_adr(r1_adr), .r1_wdata(r1_wdata), .r1_memwrite(r1_memwrite),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .m_adr(m_adr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata), .m_re(m_re),
        .m_rdata(m_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0; r0_adr = '0; r0_wdata = '0; r0_memwrite = 2'b00;
        r1_req = 1'b0; r1_adr = '0; r1_wdata = '0; r1_memwrite = 2'b00;
    endtask

    initial begin
        idle_inputs();
        m_rdata = 32'hDEADBEEF;
        reset   = 1'b0;
        r0_req  = 1'b1;
        #1;
        check("rst_gnt0",   {31'd0, r0_gnt}, 32'd0);
        check("rst_mre",    {31'd0, m_re}, 32'd0);
        check("rst_mwe",    {31'd0, m_we}, 32'd0);
        check("rst_mbe",    {28'd0, m_be}, 32'd0);
        check("rst_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
        check("rst_rdata",  r0_rdata, 32'd0);
        idle_inputs();
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        check("idle_strobes", {28'd0, m_we, m_re, r0_gnt, r1_gnt}, 32'd0);

        // word store from r0
        r0_req = 1'b1; r0_adr = 32'd84; r0_wdata = 32'hFFFF7F02; r0_memwrite = 2'b11;
        #1;
        check("ws_gnt",   {30'd0, r0_gnt, r1_gnt}, 32'd2);
        check("ws_we",    {31'd0, m_we}, 32'd1);
        check("ws_adr",   m_adr, 32'd84);
        check("ws_be",    {28'd0, m_be}, 32'hF);
        check("ws_wdata", m_wdata, 32'hFFFF7F02);
        check("ws_err",   {31'd0, r0_err}, 32'd0);
        @(negedge clk);
        idle_inputs();

        // byte store from r1
        r1_req = 1'b1; r1_adr = 32'h47; r1_wdata = 32'h0000005A; r1_memwrite = 2'b01;
        #1;
        check("bs_gnt",   {30'd0, r0_gnt, r1_gnt}, 32'd1);
        check("bs_be",    {28'd0, m_be}, 32'b1000);
        check("bs_wdata", m_wdata, 32'h5A5A5A5A);
        check("bs_adr",   m_adr, 32'h44);
        @(negedge clk);

        // half store, upper half, back to back
        r1_adr = 32'h46; r1_wdata = 32'hCAFE1234; r1_memwrite = 2'b10;
        #1;
        check("hs_gnt",   {31'd0, r1_gnt}, 32'd1);
        check("hs_be",    {28'd0, m_be}, 32'b1100);
        check("hs_wdata", m_wdata, 32'h12341234);
        @(negedge clk);
        idle_inputs();

        // read from r0; r1 arrives during data return
        r0_req = 1'b1; r0_adr = 32'h10; r0_memwrite = 2'b00;
        #1;
        check("rd_gnt", {31'd0, r0_gnt}, 32'd1);
        check("rd_re",  {31'd0, m_re}, 32'd1);
        check("rd_be",  {28'd0, m_be}, 32'hF);
        check("rd_we",  {31'd0, m_we}, 32'd0);
        check("rd_adr", m_adr, 32'h10);
        @(negedge clk);
        idle_inputs();
        r1_req = 1'b1; r1_adr = 32'h20; r1_wdata = 32'h11223344; r1_memwrite = 2'b11;
        #1;
        check("rd_rvalid0", {30'd0, r0_rvalid, r1_rvalid}, 32'd2);
        check("rd_rdata0",  r0_rdata, 32'hDEADBEEF);
        check("rd_rdata1",  r1_rdata, 32'd0);
        check("rd_nognt",   {30'd0, r0_gnt, r1_gnt}, 32'd0);
        @(negedge clk);
        #1;
        check("late_gnt1", {30'd0, r0_gnt, r1_gnt}, 32'd1);
        check("late_we",   {31'd0, m_we}, 32'd1);
        check("rd_after",  {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
        @(negedge clk);
        idle_inputs();

        // misaligned half store from r0
        r0_req = 1'b1; r0_adr = 32'h21; r0_wdata = 32'h0000BEEF; r0_memwrite = 2'b10;
        #1;
        check("mis_gnt", {31'd0, r0_gnt}, 32'd1);
        check("mis_err", {31'd0, r0_err}, 32'd1);
        check("mis_we",  {31'd0, m_we}, 32'd0);
        @(negedge clk);
        // tie after r0's rejected store goes to r1
        r0_adr = 32'h30; r0_memwrite = 2'b11;
        r1_req = 1'b1; r1_adr = 32'h34; r1_memwrite = 2'b11;
        #1;
        check("tie_after_err", {30'd0, r0_gnt, r1_gnt}, 32'd1);
        check("tie_err",       {30'd0, r0_err, r1_err}, 32'd0);
        @(negedge clk);
        idle_inputs();

        // misaligned word store
        r1_req = 1'b1; r1_adr = 32'h42; r1_memwrite = 2'b11;
        #1;
        check("misw_err", {30'd0, r1_gnt, r1_err}, 32'd3);
        check("misw_we",  {31'd0, m_we}, 32'd0);
        @(negedge clk);
        idle_inputs();

        // contention from reset: both keep requesting word reads
        reset = 1'b0;
        r0_req = 1'b1; r0_adr = 32'h100; r0_memwrite = 2'b00;
        r1_req = 1'b1; r1_adr = 32'h200; r1_memwrite = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("cont_gnt_%0d", k), {30'd0, r0_gnt, r1_gnt},
                  (k % 4 == 0) ? 32'd2 : ((k % 4 == 2) ? 32'd1 : 32'd0));
            check($sformatf("cont_rv_%0d", k), {30'd0, r0_rvalid, r1_rvalid},
                  (k % 4 == 1) ? 32'd2 : ((k % 4 == 3) ? 32'd1 : 32'd0));
            @(negedge clk);
        end

        // reset in the RDATA cycle
        @(negedge clk);
        #1;
        check("pre_rst_rv", {31'd0, r0_rvalid}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_rv",    {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
        check("mid_rst_rdata", r0_rdata, 32'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_idle", {30'd0, r0_gnt, r1_gnt}, 32'd0);
        r1_req = 1'b1; r1_adr = 32'h08; r1_memwrite = 2'b00;
        #1;
        check("post_rst_gnt", {31'd0, r1_gnt}, 32'd1);
        check("post_rst_re",  {31'd0, m_re}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post_rst_rv1", {30'd0, r0_rvalid, r1_rvalid}, 32'd1);
        check("post_rst_rd1", r1_rdata, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
